// File: rtl/count_sequence_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : count_sequence_checker_if
// Brief    : Counter-to-checker link: sampled count in, lock/error status out.
// Revision : 1.0
// ============================================================================
interface count_sequence_checker_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] q_in;
  logic             q_valid;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [7:0]       err_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output q_in, q_valid,
    input  locked, err_pulse, wrap_pulse, err_count, expected
  );

  modport slave (
    input  q_in, q_valid,
    output locked, err_pulse, wrap_pulse, err_count, expected
  );
endinterface
`default_nettype wire

// File: rtl/count_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_sequence_checker
// Brief    : Locks onto a counter's stepping direction and flags out-of-sequence
//            samples. Define COUNT_CHECK_HOLD_EN to treat a repeated value as a
//            legal stall instead of an error.
// Revision : 1.0
// ============================================================================
module count_sequence_checker #(
  parameter int WIDTH    = 3,
  parameter bit DIR_DOWN = 1'b1,
  parameter int LOCK_CNT = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  count_sequence_checker_if.slave mon
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_max      = {WIDTH{1'b1}};
  localparam logic [3:0]       c_lock     = 4'(LOCK_CNT);
  localparam logic [3:0]       c_good_one = 4'd1;

  state_t           r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_prev,       w_prev_nxt;
  logic [WIDTH-1:0] r_expected,   w_expected_nxt;
  logic [3:0]       r_good,       w_good_nxt;
  logic [7:0]       r_err_count,  w_err_count_nxt;
  logic             r_err,        w_err_nxt;
  logic             r_wrap,       w_wrap_nxt;

  logic [WIDTH-1:0] w_q_step;
  logic             w_step_ok;
  logic             w_wraps;
  logic             w_stall;

  assign w_q_step  = DIR_DOWN ? (mon.q_in - c_one) : (mon.q_in + c_one);
  assign w_step_ok = (mon.q_in == r_expected);
  assign w_wraps   = DIR_DOWN ? (r_prev == {WIDTH{1'b0}}) : (r_prev == c_max);

`ifdef COUNT_CHECK_HOLD_EN
  assign w_stall = (mon.q_in == r_prev);
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_expected  <= '0;
      r_good      <= '0;
      r_err_count <= '0;
      r_err       <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_expected  <= w_expected_nxt;
      r_good      <= w_good_nxt;
      r_err_count <= w_err_count_nxt;
      r_err       <= w_err_nxt;
      r_wrap      <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_expected_nxt  = r_expected;
    w_good_nxt      = r_good;
    w_err_count_nxt = r_err_count;
    w_err_nxt       = 1'b0;
    w_wrap_nxt      = 1'b0;

    if (mon.q_valid) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_ACQ;
          w_prev_nxt     = mon.q_in;
          w_expected_nxt = w_q_step;
          w_good_nxt     = '0;
        end
        S_ACQ, S_LOCKED: begin
          if (!w_stall) begin
            w_prev_nxt     = mon.q_in;
            w_expected_nxt = w_q_step;
            if (w_step_ok) begin
              w_wrap_nxt = w_wraps;
              if (r_state == S_ACQ) begin
                w_good_nxt = r_good + c_good_one;
                if (w_good_nxt == c_lock) begin
                  w_state_nxt = S_LOCKED;
                end
              end
            end else begin
              w_good_nxt = '0;
              // Mismatches only count as errors once lock has been acquired
              if (r_state == S_LOCKED) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_ACQ;
                if (r_err_count != 8'hFF) begin
                  w_err_count_nxt = r_err_count + 8'd1;
                end
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign mon.locked     = (r_state == S_LOCKED);
  assign mon.err_pulse  = r_err;
  assign mon.wrap_pulse = r_wrap;
  assign mon.err_count  = r_err_count;
  assign mon.expected   = r_expected;

endmodule
`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_sequence_checker
// Brief    : Directed and random checks of a down (lock 2) and an up (lock 3)
//            checker against a sequence-rule model.
// Revision : 1.0
// ============================================================================
module tb_count_sequence_checker;

  localparam int c_mod   = 8;
  localparam int c_lock0 = 2;
  localparam int c_lock1 = 3;
  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;
`ifdef COUNT_CHECK_HOLD_EN
  localparam bit c_hold_en = 1'b1;
`else
  localparam bit c_hold_en = 1'b0;
`endif

  logic clk;
  logic rst;

  count_sequence_checker_if #(.WIDTH(3)) bus0 ();
  count_sequence_checker_if #(.WIDTH(3)) bus1 ();

  count_sequence_checker #(.WIDTH(3), .DIR_DOWN(1'b1), .LOCK_CNT(c_lock0)) dut0 (
    .clk (clk),
    .rst (rst),
    .mon (bus0)
  );

  count_sequence_checker #(.WIDTH(3), .DIR_DOWN(1'b0), .LOCK_CNT(c_lock1)) dut1 (
    .clk (clk),
    .rst (rst),
    .mon (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int mode;
    int prev;
    int good;
    int errs;
    int exp;
    bit err;
    bit wrap;
  } mdl_t;

  mdl_t m0, m1;
  int   n_cmp;
  int   n_bad;

  task automatic check_value(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int v, input bit down);
    return down ? (v + c_mod - 1) % c_mod : (v + 1) % c_mod;
  endfunction

  function automatic mdl_t model_step(input mdl_t m, input bit r, input bit v,
                                      input int q, input bit down, input int lockn);
    mdl_t n;
    n      = m;
    n.err  = 1'b0;
    n.wrap = 1'b0;
    if (r) begin
      n.mode = M_IDLE; n.prev = 0; n.good = 0; n.errs = 0; n.exp = 0;
      return n;
    end
    if (!v) return n;
    if (m.mode == M_IDLE) begin
      n.mode = M_ACQ; n.prev = q; n.good = 0; n.exp = nxt(q, down);
    end else if (!(c_hold_en && q == m.prev)) begin
      n.prev = q;
      n.exp  = nxt(q, down);
      if (q == nxt(m.prev, down)) begin
        n.wrap = (down && m.prev == 0 && q == c_mod - 1) ||
                 (!down && m.prev == c_mod - 1 && q == 0);
        if (m.mode == M_ACQ) begin
          n.good = m.good + 1;
          if (n.good == lockn) n.mode = M_LOCKED;
        end
      end else begin
        n.good = 0;
        if (m.mode == M_LOCKED) begin
          n.err  = 1'b1;
          n.mode = M_ACQ;
          if (m.errs < 255) n.errs = m.errs + 1;
        end
      end
    end
    return n;
  endfunction

  // kind: 1 correct step, 2 wrong value, 3 repeat previous, other random
  function automatic int pick(input mdl_t m, input int kind, input bit down);
    case (kind)
      1:       return nxt(m.prev, down);
      2:       return (nxt(m.prev, down) + 2) % c_mod;
      3:       return m.prev;
      default: return int'($urandom_range(0, c_mod - 1));
    endcase
  endfunction

  task automatic cycle(input bit r, input bit v0, input int q0, input bit v1, input int q1);
    rst          = r;
    bus0.q_valid = v0;
    bus0.q_in    = 3'(q0);
    bus1.q_valid = v1;
    bus1.q_in    = 3'(q1);
    @(posedge clk);
    m0 = model_step(m0, r, v0, q0, 1'b1, c_lock0);
    m1 = model_step(m1, r, v1, q1, 1'b0, c_lock1);
    @(negedge clk);
    check_value("d0.locked",    bus0.locked,     int'(m0.mode == M_LOCKED));
    check_value("d0.err_pulse", bus0.err_pulse,  int'(m0.err));
    check_value("d0.wrap",      bus0.wrap_pulse, int'(m0.wrap));
    check_value("d0.err_count", bus0.err_count,  m0.errs);
    check_value("d0.expected",  bus0.expected,   m0.exp);
    check_value("d1.locked",    bus1.locked,     int'(m1.mode == M_LOCKED));
    check_value("d1.err_pulse", bus1.err_pulse,  int'(m1.err));
    check_value("d1.wrap",      bus1.wrap_pulse, int'(m1.wrap));
    check_value("d1.err_count", bus1.err_count,  m1.errs);
    check_value("d1.expected",  bus1.expected,   m1.exp);
  endtask

  task automatic feed0(input int q);
    cycle(1'b0, 1'b1, q, 1'b1, pick(m1, 1, 1'b0));
  endtask

  task automatic step2(input int k0, input int k1, input bit r);
    cycle(r, k0 != 0, pick(m0, k0, 1'b1), k1 != 0, pick(m1, k1, 1'b0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m0    = '0;
    m1    = '0;
    rst   = 1'b1;
    bus0.q_valid = 1'b0; bus0.q_in = '0;
    bus1.q_valid = 1'b0; bus1.q_in = '0;

    cycle(1'b1, 1'b0, 0, 1'b0, 0);
    cycle(1'b1, 1'b1, 3, 1'b1, 3);

    // down-count acquisition
    feed0(5); feed0(4); feed0(3);
    check_value("t1.locked", bus0.locked, 1);
    check_value("t1.err_count", bus0.err_count, 0);
    feed0(2);

    // wrap through zero
    feed0(1); feed0(0); feed0(7);
    check_value("t2.wrap", bus0.wrap_pulse, 1);
    feed0(6);
    check_value("t2.wrap_clear", bus0.wrap_pulse, 0);
    check_value("t2.locked", bus0.locked, 1);

    // single wrong value, then relock
    feed0(5); feed0(4);
    check_value("t3.expected", bus0.expected, 3);
    feed0(5);
    check_value("t3.err", bus0.err_pulse, 1);
    check_value("t3.locked", bus0.locked, 0);
    check_value("t3.err_count", bus0.err_count, 1);
    feed0(4); feed0(3);
    check_value("t3.relock", bus0.locked, 1);

    // held value
    feed0(2); feed0(1); feed0(0); feed0(7); feed0(6); feed0(6);
`ifdef COUNT_CHECK_HOLD_EN
    check_value("t4.hold_err", bus0.err_pulse, 0);
    check_value("t4.hold_locked", bus0.locked, 1);
`else
    check_value("t4.hold_err", bus0.err_pulse, 1);
    check_value("t4.hold_count", bus0.err_count, 2);
`endif

    // reset together with a valid sample while errors are pending
    for (int i = 0; i < 20 && m0.errs < 4; i++) begin
      step2(1, 1, 1'b0); step2(1, 1, 1'b0); step2(2, 1, 1'b0);
    end
    check_value("t6.pre_count", bus0.err_count, 4);
    step2(2, 2, 1'b1);
    check_value("t6.locked", bus0.locked, 0);
    check_value("t6.err_count", bus0.err_count, 0);
    step2(2, 2, 1'b0);
    check_value("t6.first_err", bus0.err_pulse, 0);

    for (int i = 0; i < 3000; i++) begin
      int k0, k1, sel;
      sel = int'($urandom_range(0, 99));
      k0  = (sel < 10) ? 0 : (sel < 75) ? 1 : (sel < 85) ? 2 : (sel < 93) ? 3 : 4;
      sel = int'($urandom_range(0, 99));
      k1  = (sel < 10) ? 0 : (sel < 75) ? 1 : (sel < 85) ? 2 : (sel < 93) ? 3 : 4;
      step2(k0, k1, $urandom_range(0, 199) == 0);
    end

    // saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      step2(1, 1, 1'b0); step2(1, 1, 1'b0); step2(1, 1, 1'b0);
      step2(2, 2, 1'b0);
    end
    check_value("t5.sat0", bus0.err_count, 255);
    check_value("t5.sat1", bus1.err_count, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
